// File: rtl/mac_dot_accum.sv
`default_nettype none
// ============================================================================
// Module   : mac_dot_accum
// Purpose  : 3-stage multi-lane dot-product MAC with frame accumulator,
//            optional saturation and ready/valid result output.
// Revision : 1.0 - initial release
// ============================================================================
module mac_dot_accum #(
   parameter int A_W      = 8,
   parameter int B_W      = 8,
   parameter int LANES    = 4,
   parameter int ACC_W    = 32,
   parameter int SIGNED   = 0,
   parameter int SATURATE = 1
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [LANES*A_W-1:0]   a,
   input  logic [LANES*B_W-1:0]   b,
   input  logic                   in_first,
   input  logic                   in_last,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [ACC_W-1:0]       y,
   output logic                   y_ovf
);

   localparam int c_prod_w = A_W + B_W;
   localparam int c_sum_w  = A_W + B_W + $clog2(LANES);
   localparam int c_ext_w  = ACC_W + 1;
   localparam logic [ACC_W-1:0] c_smax = {1'b0, {(ACC_W-1){1'b1}}};
   localparam logic [ACC_W-1:0] c_smin = {1'b1, {(ACC_W-1){1'b0}}};

   generate
      if (ACC_W < c_sum_w) begin : g_acc_w_check
         $error("mac_dot_accum: ACC_W narrower than A_W+B_W+clog2(LANES)");
      end
   endgenerate

   logic w_stall;
   assign w_stall  = out_valid && !out_ready;
   assign in_ready = !w_stall;

   // Stage 1: operand capture
   logic                 r_s1_valid, r_s1_first, r_s1_last;
   logic [LANES*A_W-1:0] r_s1_a;
   logic [LANES*B_W-1:0] r_s1_b;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s1_valid <= 1'b0;
         r_s1_first <= 1'b0;
         r_s1_last  <= 1'b0;
         r_s1_a     <= '0;
         r_s1_b     <= '0;
      end else if (!w_stall) begin
         r_s1_valid <= in_valid;
         r_s1_first <= in_first;
         r_s1_last  <= in_last;
         r_s1_a     <= a;
         r_s1_b     <= b;
      end
   end

   // Stage 2: lane products, extended to the adder-tree width
   logic [c_sum_w-1:0] w_prod_ext [LANES];

   generate
      for (genvar i = 0; i < LANES; i++) begin : g_lane
         if (SIGNED != 0) begin : g_signed
            logic signed [c_prod_w-1:0] w_prod;
            assign w_prod = c_prod_w'($signed(r_s1_a[i*A_W +: A_W])) *
                            c_prod_w'($signed(r_s1_b[i*B_W +: B_W]));
            assign w_prod_ext[i] = c_sum_w'(w_prod);
         end else begin : g_unsigned
            logic [c_prod_w-1:0] w_prod;
            assign w_prod = c_prod_w'(r_s1_a[i*A_W +: A_W]) *
                            c_prod_w'(r_s1_b[i*B_W +: B_W]);
            assign w_prod_ext[i] = c_sum_w'(w_prod);
         end
      end
   endgenerate

   logic [c_sum_w-1:0] w_dot;
   always_comb begin
      w_dot = '0;
      for (int i = 0; i < LANES; i++) begin
         w_dot = w_dot + w_prod_ext[i];
      end
   end

   logic               r_s2_valid, r_s2_first, r_s2_last;
   logic [c_sum_w-1:0] r_s2_sum;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s2_valid <= 1'b0;
         r_s2_first <= 1'b0;
         r_s2_last  <= 1'b0;
         r_s2_sum   <= '0;
      end else if (!w_stall) begin
         r_s2_valid <= r_s1_valid;
         r_s2_first <= r_s1_first;
         r_s2_last  <= r_s1_last;
         r_s2_sum   <= w_dot;
      end
   end

   // Stage 3: accumulate one bit wider than ACC_W so overflow is visible
   logic [ACC_W-1:0]   r_acc;
   logic               r_ovf;
   logic [ACC_W-1:0]   w_base, w_acc_new;
   logic [c_ext_w-1:0] w_base_ext, w_dot_ext, w_res;
   logic               w_ovf, w_ovf_new;

   assign w_base = r_s2_first ? '0 : r_acc;

   generate
      if (SIGNED != 0) begin : g_ext_signed
         assign w_dot_ext  = c_ext_w'($signed(r_s2_sum));
         assign w_base_ext = c_ext_w'($signed(w_base));
         assign w_ovf      = w_res[ACC_W] ^ w_res[ACC_W-1];
      end else begin : g_ext_unsigned
         assign w_dot_ext  = c_ext_w'(r_s2_sum);
         assign w_base_ext = {1'b0, w_base};
         assign w_ovf      = w_res[ACC_W];
      end
   endgenerate

   assign w_res     = w_base_ext + w_dot_ext;
   assign w_ovf_new = (r_s2_first ? 1'b0 : r_ovf) | w_ovf;

   always_comb begin
      w_acc_new = w_res[ACC_W-1:0];
      if (w_ovf && (SATURATE != 0)) begin
         if (SIGNED != 0) begin
            w_acc_new = w_res[ACC_W] ? c_smin : c_smax;
         end else begin
            w_acc_new = '1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_acc     <= '0;
         r_ovf     <= 1'b0;
         y         <= '0;
         y_ovf     <= 1'b0;
         out_valid <= 1'b0;
      end else if (!w_stall) begin
         // Not stalled means the output is empty or transferring this cycle.
         out_valid <= r_s2_valid && r_s2_last;
         if (r_s2_valid) begin
            if (r_s2_last) begin
               y     <= w_acc_new;
               y_ovf <= w_ovf_new;
               r_acc <= '0;
               r_ovf <= 1'b0;
            end else begin
               r_acc <= w_acc_new;
               r_ovf <= w_ovf_new;
            end
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_mac_dot_accum.sv
`default_nettype none
// ============================================================================
// Module   : tb_mac_dot_accum
// Purpose  : scoreboard bench for mac_dot_accum (four parameterisations).
// Revision : 1.0 - initial release
// ============================================================================
module tb_mac_dot_accum;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // DUT0: default configuration
   logic        rst_n, in_valid, in_first, in_last, out_ready;
   logic [31:0] a, b;
   logic        in_ready, out_valid, y_ovf;
   logic [31:0] y;

   // Shared bus for DUT1 (signed), DUT2 (20-bit sat), DUT3 (20-bit wrap)
   logic        v2, f2, l2;
   logic [31:0] a2, b2;
   logic        ir1, ov1, yo1, ir2, ov2, yo2, ir3, ov3, yo3;
   logic [31:0] y1;
   logic [19:0] y2, y3;

   mac_dot_accum u_dut0 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .in_first(in_first), .in_last(in_last),
      .out_valid(out_valid), .out_ready(out_ready), .y(y), .y_ovf(y_ovf));

   mac_dot_accum #(.SIGNED(1)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .in_valid(v2), .in_ready(ir1),
      .a(a2), .b(b2), .in_first(f2), .in_last(l2),
      .out_valid(ov1), .out_ready(1'b1), .y(y1), .y_ovf(yo1));

   mac_dot_accum #(.ACC_W(20), .SATURATE(1)) u_dut2 (
      .clk(clk), .rst_n(rst_n), .in_valid(v2), .in_ready(ir2),
      .a(a2), .b(b2), .in_first(f2), .in_last(l2),
      .out_valid(ov2), .out_ready(1'b1), .y(y2), .y_ovf(yo2));

   mac_dot_accum #(.ACC_W(20), .SATURATE(0)) u_dut3 (
      .clk(clk), .rst_n(rst_n), .in_valid(v2), .in_ready(ir3),
      .a(a2), .b(b2), .in_first(f2), .in_last(l2),
      .out_valid(ov3), .out_ready(1'b1), .y(y3), .y_ovf(yo3));

   int total = 0;
   int bad   = 0;
   int stalls = 0;
   logic [32:0] q0[$], q1[$], q2[$], q3[$];   // {ovf, y}
   logic bp_en = 1'b0, hold = 1'b0;
   int   bp_cnt = 0;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", nm, act, act, exp, exp, $time);
      end
   endtask

   function automatic logic [31:0] p4(input logic [7:0] l0, l1, l2, l3);
      return {l3, l2, l1, l0};
   endfunction

   // Output-ready driver: changes just after the rising edge
   initial begin
      out_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         if (bp_en) begin
            bp_cnt++;
            out_ready = (bp_cnt % 8) >= 5;
         end else begin
            out_ready = !hold;
         end
      end
   end

   // Monitor: compares every transferred result against the scoreboard
   logic        prev_hold = 1'b0;
   logic [31:0] prev_y;
   logic        prev_yo;
   always @(negedge clk) begin
      logic [32:0] e;
      if (!rst_n) begin
         prev_hold = 1'b0;
      end else begin
         check("in_ready_rule", 32'(in_ready), 32'(!(out_valid && !out_ready)));
         if (prev_hold) begin
            check("hold_valid", 32'(out_valid), 32'd1);
            check("hold_y", y, prev_y);
            check("hold_ovf", 32'(y_ovf), 32'(prev_yo));
         end
         if (out_valid && out_ready) begin
            if (q0.size() == 0) begin
               total++; bad++;
               $display("FAIL dut0_extra: got y=%0d expected no result", y);
            end else begin
               e = q0.pop_front();
               check("dut0_y", y, e[31:0]);
               check("dut0_ovf", 32'(y_ovf), 32'(e[32]));
            end
         end
         prev_hold = out_valid && !out_ready;
         prev_y    = y;
         prev_yo   = y_ovf;
         if (ov1) begin
            if (q1.size() == 0) begin
               total++; bad++; $display("FAIL dut1_extra: got y=%0d expected no result", y1);
            end else begin
               e = q1.pop_front();
               check("dut1_y", y1, e[31:0]);
               check("dut1_ovf", 32'(yo1), 32'(e[32]));
            end
         end
         if (ov2) begin
            if (q2.size() == 0) begin
               total++; bad++; $display("FAIL dut2_extra: got y=%0d expected no result", y2);
            end else begin
               e = q2.pop_front();
               check("dut2_y", 32'(y2), e[31:0]);
               check("dut2_ovf", 32'(yo2), 32'(e[32]));
            end
         end
         if (ov3) begin
            if (q3.size() == 0) begin
               total++; bad++; $display("FAIL dut3_extra: got y=%0d expected no result", y3);
            end else begin
               e = q3.pop_front();
               check("dut3_y", 32'(y3), e[31:0]);
               check("dut3_ovf", 32'(yo3), 32'(e[32]));
            end
         end
      end
   end

   task automatic send(input logic [31:0] av, bv, input logic f, l);
      int n = 0;
      @(negedge clk);
      in_valid = 1'b1; a = av; b = bv; in_first = f; in_last = l;
      while (!in_ready) begin
         stalls++;
         n++;
         if (n > 200) begin
            $display("FAIL send_timeout: in_ready low for %0d cycles, required at most 200", n);
            $fatal(1);
         end
         @(negedge clk);
      end
      @(posedge clk);
   endtask

   task automatic idle();
      @(negedge clk);
      in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
   endtask

   task automatic send2(input logic [31:0] av, bv, input logic f, l);
      @(negedge clk);
      v2 = 1'b1; a2 = av; b2 = bv; f2 = f; l2 = l;
      @(posedge clk);
   endtask

   task automatic drain(input int budget);
      int n = 0;
      while ((q0.size() + q1.size() + q2.size() + q3.size()) != 0 && n < budget) begin
         @(posedge clk);
         n++;
      end
      check("drain_pending", 32'(q0.size() + q1.size() + q2.size() + q3.size()), 32'd0);
   endtask

   task automatic rand_frame();
      int len;
      int exp;
      logic [31:0] av, bv;
      len = $urandom_range(1, 4);
      exp = 0;
      for (int i = 0; i < len; i++) begin
         av = $urandom;
         bv = $urandom;
         for (int k = 0; k < 4; k++) begin
            exp += int'(av[8*k +: 8]) * int'(bv[8*k +: 8]);
         end
         if (i == len - 1) q0.push_back({1'b0, 32'(exp)});
         send(av, bv, i == 0, i == len - 1);
      end
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time exceeded");
      $fatal(1);
   end

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0; a = '0; b = '0;
      v2 = 1'b0; f2 = 1'b0; l2 = 1'b0; a2 = '0; b2 = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_y", y, 32'd0);
      check("rst_y_ovf", 32'(y_ovf), 32'd0);
      check("rst_in_ready", 32'(in_ready), 32'd1);
      @(negedge clk);
      rst_n = 1'b1;

      // Single beat, first=last: 1*5+2*6+3*7+4*8 = 70, visible at E+2 for one cycle
      q0.push_back({1'b0, 32'd70});
      send(p4(8'd1, 8'd2, 8'd3, 8'd4), p4(8'd5, 8'd6, 8'd7, 8'd8), 1'b1, 1'b1);
      idle();
      @(posedge clk); #1 check("t1_lat_e1", 32'(out_valid), 32'd0);
      @(posedge clk); #1 check("t1_lat_e2", 32'(out_valid), 32'd1);
      check("t1_y_e2", y, 32'd70);
      @(posedge clk); #1 check("t1_lat_e3", 32'(out_valid), 32'd0);

      // Back-to-back frames: 70+70+10 = 150, then 70
      stalls = 0;
      q0.push_back({1'b0, 32'd150});
      q0.push_back({1'b0, 32'd70});
      send(p4(8'd1, 8'd2, 8'd3, 8'd4), p4(8'd5, 8'd6, 8'd7, 8'd8), 1'b1, 1'b0);
      send(p4(8'd1, 8'd2, 8'd3, 8'd4), p4(8'd5, 8'd6, 8'd7, 8'd8), 1'b0, 1'b0);
      send(p4(8'd1, 8'd2, 8'd3, 8'd4), p4(8'd1, 8'd1, 8'd1, 8'd1), 1'b0, 1'b1);
      send(p4(8'd1, 8'd2, 8'd3, 8'd4), p4(8'd5, 8'd6, 8'd7, 8'd8), 1'b1, 1'b1);
      idle();
      check("t2_no_stall", 32'(stalls), 32'd0);
      drain(50);

      // Random frames under periodic backpressure
      bp_en = 1'b1;
      repeat (4) rand_frame();
      idle();
      drain(500);
      bp_en = 1'b0;
      repeat (2) @(posedge clk);

      // Signed: 4 * (-128*127) = -65024; unsigned 20-bit DUTs see 4*128*127 = 65024
      q1.push_back({1'b0, 32'hFFFF_0200});
      q2.push_back({1'b0, 32'd65024});
      q3.push_back({1'b0, 32'd65024});
      send2(p4(8'h80, 8'h80, 8'h80, 8'h80), p4(8'h7F, 8'h7F, 8'h7F, 8'h7F), 1'b1, 1'b1);
      // Five beats of 4*255*255 = 1300500 total; signed view is 5*4*(-1*-1) = 20
      q1.push_back({1'b0, 32'd20});
      q2.push_back({1'b1, 32'h000F_FFFF});
      q3.push_back({1'b1, 32'd251924});
      for (int i = 0; i < 5; i++) begin
         send2(32'hFFFF_FFFF, 32'hFFFF_FFFF, i == 0, i == 4);
      end
      q1.push_back({1'b0, 32'd1});
      q2.push_back({1'b0, 32'd1});
      q3.push_back({1'b0, 32'd1});
      send2(p4(8'd1, 8'd0, 8'd0, 8'd0), p4(8'd1, 8'd0, 8'd0, 8'd0), 1'b1, 1'b1);
      @(negedge clk);
      v2 = 1'b0; f2 = 1'b0; l2 = 1'b0;
      drain(50);

      // Asynchronous reset while a result is held and a frame is in flight
      hold = 1'b1;
      @(posedge clk); #2;
      send(p4(8'd1, 8'd2, 8'd3, 8'd4), p4(8'd5, 8'd6, 8'd7, 8'd8), 1'b1, 1'b1);
      send(p4(8'd1, 8'd2, 8'd3, 8'd4), p4(8'd5, 8'd6, 8'd7, 8'd8), 1'b1, 1'b0);
      idle();
      repeat (4) @(posedge clk);
      #2;
      check("t6_pre_valid", 32'(out_valid), 32'd1);
      check("t6_pre_y", y, 32'd70);
      rst_n = 1'b0;
      #1;
      check("t6_rst_valid", 32'(out_valid), 32'd0);
      check("t6_rst_y", y, 32'd0);
      check("t6_rst_y_ovf", 32'(y_ovf), 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      hold = 1'b0;
      @(posedge clk); #2;

      q0.push_back({1'b0, 32'd70});
      send(p4(8'd1, 8'd2, 8'd3, 8'd4), p4(8'd5, 8'd6, 8'd7, 8'd8), 1'b0, 1'b1);
      q0.push_back({1'b0, 32'd10});
      send(p4(8'd1, 8'd2, 8'd3, 8'd4), p4(8'd5, 8'd6, 8'd7, 8'd8), 1'b1, 1'b0);
      send(p4(8'd1, 8'd2, 8'd3, 8'd4), p4(8'd5, 8'd6, 8'd7, 8'd8), 1'b0, 1'b0);
      send(p4(8'd1, 8'd2, 8'd3, 8'd4), p4(8'd1, 8'd1, 8'd1, 8'd1), 1'b1, 1'b1);
      idle();
      drain(50);
      repeat (3) @(posedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/mac_dot_accum.md
Name: mac_dot_accum

Overview:
- Multi-lane, pipelined dot-product MAC with an internal frame accumulator and saturation.
- Each accepted beat multiplies LANES operand pairs, sums the products, and adds the sum into a running accumulator.
- A beat flagged last emits the frame result on a ready/valid output.
- It sits downstream of operand fetch and upstream of result writeback in the compute datapath.

Parameters:
- A_W, 8, width of each lane's a operand.
- B_W, 8, width of each lane's b operand.
- LANES, 4, multiplier lanes per beat (≥1).
- ACC_W, 32, accumulator/output width. Must be ≥ A_W+B_W+$clog2(LANES); elaboration error otherwise.
- SIGNED, 0, 1 = two's-complement operands and accumulator; 0 = unsigned.
- SATURATE, 1, 1 = clamp on overflow; 0 = wrap modulo 2^ACC_W.

Ports:
- clk, in, 1, clock; all logic on the rising edge.
- rst_n, in, 1, asynchronous active-low reset.
- in_valid, in, 1, input beat valid.
- in_ready, out, 1, block can accept a beat.
- a, in, LANES*A_W, lane operands; lane i = a[i*A_W +: A_W].
- b, in, LANES*B_W, lane operands; lane i = b[i*B_W +: B_W].
- in_first, in, 1, beat starts a new frame (accumulator restarts from this beat's sum).
- in_last, in, 1, beat ends the frame; result is emitted.
- out_valid, out, 1, result valid.
- out_ready, in, 1, consumer accepts result.
- y, out, ACC_W, frame result.
- y_ovf, out, 1, sticky: at least one overflow occurred in this frame.

Behaviour:
- Reset: one clock, clk. Reset is asynchronous and active-low on rst_n. While rst_n=0, all stage valids, accumulator, ovf flag, y, y_ovf and out_valid are 0. Partial frames are discarded.
- Handshake: a beat is accepted when in_valid && in_ready. The source holds the beat stable while in_valid && !in_ready. A result transfers when out_valid && out_ready.
- Stall: stall = out_valid && !out_ready; in_ready = !stall. When stall=1, every pipeline register, the accumulator and the output register hold. Nothing is accumulated twice or dropped.
- Pipeline: 3 stages, throughput of one beat per cycle when not stalled.
  - S1: registers a, b, first, last, and valid.
  - S2: computes LANES products at width A_W+B_W (signed or unsigned per SIGNED), then an adder tree to width A_W+B_W+$clog2(LANES), registered.
  - S3: accumulate and output.
- Latency: for a last beat accepted at edge E with no stall, out_valid and y update at edge E+2.
- Accumulate rule in S3, applied when the S2 beat is valid and there is no stall:
  - base = first ? 0 : acc.
  - sum is sign-extended (SIGNED) or zero-extended to ACC_W+1 and added to base.
  - Overflow is detected in the ACC_W+1-bit result against the ACC_W range.
  - SATURATE=1: clamp to max/min representable. SATURATE=0: keep the low ACC_W bits.
  - The ovf flag is set if overflow occurs and is cleared when first=1 (before OR-ing the current beat).
- Last beat:
  - y ← new acc, y_ovf ← new ovf flag, out_valid ← 1.
  - acc and ovf flag clear to 0, so the next frame starts from zero even if first=0.
- first && last on the same beat: single-beat frame; y = that beat's sum.
- first mid-frame: the partial sum is discarded and the frame restarts.
- Output: out_valid clears on transfer unless a new last beat loads in the same cycle. That case can occur only when out_ready=1, and out_valid stays 1 with the new y. y and y_ovf are stable while out_valid && !out_ready.
- in_valid=0 bubbles propagate without changing acc.

Test Plan:
1. Defaults. Single beat, first=last=1, a lanes {1,2,3,4}, b lanes {5,6,7,8}, out_ready=1 -> y=70, y_ovf=0, out_valid high for exactly 1 cycle, at edge E+2.
2. Back-to-back 3-beat frame with beat sums 70, 70, 10, followed immediately by a 1-beat frame with sum 70 -> y=150, then y=70 on consecutive out_valid cycles. in_ready stays 1 throughout.
3. Backpressure: stream 4 random frames while toggling out_ready low for 5-cycle windows -> in_ready=0 exactly when out_valid && !out_ready; y held stable; all results match the reference model, with no loss or duplication.
4. SIGNED=1: all lanes a=-128, b=127, single-beat frame -> y=32'hFFFF0200 (-65024), y_ovf=0.
5. ACC_W=20, unsigned, all lanes a=b=255, 5-beat frame (raw total 1300500):
   - SATURATE=1 -> y=20'hFFFFF, y_ovf=1.
   - SATURATE=0 -> y=251924, y_ovf=1.
   - Next 1-beat frame with sum 1 -> y=1, y_ovf=0.
6. Reset and mid-frame first:
   - Drive rst_n low asynchronously mid-frame -> out_valid, y, y_ovf go 0 immediately without a clock edge.
   - After release, a beat with first=0, last=1 and sum 70 -> y=70.
   - A frame of 2 beats (sum 70 each), then a first=1 beat with sum 10 and last=1 -> y=10.
